spike_rate_meter: RTL and testbench
===================================

Name: spike_rate_meter

Overview:
Multi-channel, windowed spike-rate meter. It is the parametrised successor to the per-wordline high/low level counters and dividers. For each of CH input lines it counts high cycles and low cycles over a programmable window, then snapshots both counts at window end. One shared sequential divider then computes a fixed-point high/low ratio per channel, and the results stream out channel by channel over a valid/ready handshake to downstream spike-encoding logic.

Parameters:
CH, 32, number of monitored lines
CNT_W, 16, high/low counter width; WIN must be <= 2^CNT_W-1
WIN, 1024, window length in clk cycles (>= 2)
FRAC_W, 8, fractional bits of the ratio
Q_W, 16, result width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  measurement enable; windows advance only while high
wlord  in  CH  monitored lines, sampled each clk
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_ch  out  clog2(CH)  channel index of the current result
out_rate  out  Q_W  floor(high*2^FRAC_W/low), saturated
busy  out  1  snapshot bank being divided or emitted
overrun  out  1  sticky; a window end was dropped

Behaviour:
- Reset values: all counters 0, window counter 0, state IDLE, out_valid=0, out_ch=0, out_rate=0, busy=0, overrun=0.
- Counting, per channel i, while en=1:
  - hi[i]++ when wlord[i]=1, else lo[i]++.
  - Both counters saturate at all-ones.
  - While en=0, counting and the window counter hold.
- Window end:
  - The window counter runs 0..WIN-1.
  - On the cycle it equals WIN-1, that cycle's sample is included.
  - If the FSM is IDLE, the hi/lo arrays are copied to snapshot arrays, the live counters clear to 0 the next cycle, and the FSM goes to LOAD with ch=0.
  - If the FSM is not IDLE, the snapshot is unchanged, overrun<=1, and the live counters still clear.
  - overrun clears only on rst.
- Result FSM:
  - IDLE: wait for a snapshot.
  - LOAD (1 cycle): dividend={snap_hi[ch], FRAC_W zeros}, divisor=snap_lo[ch]. If divisor==0, skip to OUT with rate=all-ones; otherwise go to DIV.
  - DIV: restoring divider, one quotient bit per cycle, DW=CNT_W+FRAC_W cycles. The quotient is saturated to Q_W bits (all-ones if it exceeds), then go to OUT.
  - OUT: out_valid=1. out_ch and out_rate are stable until the out_valid&&out_ready handshake. On handshake: if ch==CH-1, go to IDLE; else ch++ and go to LOAD.
- Latency per channel with out_ready=1:
  - Nonzero divisor: 1+DW+1 cycles.
  - Zero divisor: 2 cycles.
- busy=1 in every state except IDLE.
- The divider and FSM ignore en; a bank in flight always completes.
- rst at any time aborts the division, discards the snapshot, and returns all registers to reset values with no partial output.
- Simultaneous window end and final handshake (state OUT, ch==CH-1, handshake same cycle): treated as not-IDLE, so the window is dropped and overrun is set.

Optional Feature:
SPR_RAW_OUT_EN:
- Defined: adds ports out_hi (CNT_W) and out_lo (CNT_W), carrying snap_hi/snap_lo of out_ch. They are valid with out_valid and reset to 0.
- Undefined: these ports and their muxing are absent; the core behaviour is identical.

Decomposition:
- Package spr_pkg holds:
  - the FSM state enum (IDLE, LOAD, DIV, OUT)
  - a DW localparam helper function
  - the saturation constant helper
- One sub-module, spr_seq_divider: start/done handshake, DW-cycle restoring divide, div-by-zero flag.
- Per-channel counters are a generate loop in the top module, not a sub-module.

Test Plan:
Shared setup for all scenarios: CH=2, WIN=16, CNT_W=8, FRAC_W=4, Q_W=8, out_ready=1 unless stated.
- Basic ratio: wlord[1] alternates 1/0 for one window -> out_ch=1, out_rate=0x10, exactly 14 cycles after the ch0 handshake.
- Divide-by-zero: wlord[0] held 1 -> out_ch=0, out_rate=0xFF, out_valid 2 cycles after the window end.
- Asymmetric: wlord[1] high 12 of 16 cycles -> out_rate=0x30. Shortening the high time to 1 of 16 cycles -> 16/15 floor = 0x01.
- Saturation: FRAC_W=4, Q_W=4, hi=15, lo=1 -> quotient 240 saturates to out_rate=0xF.
- Backpressure/overrun: out_ready=0 through two window ends -> second window dropped, overrun=1 sticky, ch0 result unchanged. Releasing out_ready emits the first bank only.
- Reset mid-DIV: assert rst 5 cycles into DIV -> next cycle out_valid=0, busy=0, counters 0. The next full window yields correct results with no stale output.

Source files
------------

// File: rtl/spike_rate_meter_pkg.sv
// Shared types and sizing helpers for the spike-rate meter.
// Optional macro SPR_RAW_OUT_EN (used by the interface and top) exposes the raw snapshot counts.
package spr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    OUT
  } spr_state_e;

  // Dividend width: the high count shifted left by the fractional bits.
  function automatic int sprDivWidth(input int cntW, input int fracW);
    return cntW + fracW;
  endfunction

  function automatic logic [63:0] sprSatMax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int sprIdxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_rate_meter_if.sv
// Result stream from the meter to the spike-encoding logic.
// With SPR_RAW_OUT_EN defined, the raw snapshot counts travel alongside each result.
interface spike_rate_meter_if
  import spr_pkg::*;
#(
  parameter int CH  = 32,
  parameter int Q_W = 16
`ifdef SPR_RAW_OUT_EN
  , parameter int CNT_W = 16
`endif
) ();

  localparam int CH_W = sprIdxWidth(CH);

  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [Q_W-1:0]  out_rate;
`ifdef SPR_RAW_OUT_EN
  logic [CNT_W-1:0] out_hi;
  logic [CNT_W-1:0] out_lo;
`endif

  modport master (
    output out_valid,
    output out_ch,
    output out_rate,
`ifdef SPR_RAW_OUT_EN
    output out_hi,
    output out_lo,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_rate,
`ifdef SPR_RAW_OUT_EN
    input  out_hi,
    input  out_lo,
`endif
    output out_ready
  );

endinterface

// File: rtl/spike_rate_meter_divider.sv
// Restoring divider producing one quotient bit per cycle over DW cycles.
// done_o marks the final iteration; quotient_o then already holds the finished result.
module spr_seq_divider
  import spr_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 8,
  localparam int DW    = sprDivWidth(CNT_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DW-1:0]    dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             divByZero_o,
  output logic             done_o,
  output logic [DW-1:0]    quotient_o
);

  localparam int IW = $clog2(DW);

  logic [DW-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dsr_q, dsr_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [CNT_W:0]   trial;

  assign divByZero_o = (divisor_i == '0);

  // The dividend shifts out of quo from the top while quotient bits fill in from the bottom.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_o = 1'b0;
    trial  = {rem_q, quo_q[DW-1]};
    if (start_i && !divByZero_o) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      quo_d = {quo_q[DW-2:0], 1'b0};
      rem_d = trial[CNT_W-1:0];
      if (trial >= {1'b0, dsr_q}) begin
        rem_d    = CNT_W'(trial - {1'b0, dsr_q});
        quo_d[0] = 1'b1;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(DW - 1)) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end
    end
    quotient_o = quo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/spike_rate_meter.sv
// Windowed per-line high/low counters feeding one shared divider that streams high/low ratios.
// Define SPR_RAW_OUT_EN to also present the snapshot counts of the current channel.
module spike_rate_meter
  import spr_pkg::*;
#(
  parameter int CH     = 32,
  parameter int CNT_W  = 16,
  parameter int WIN    = 1024,
  parameter int FRAC_W = 8,
  parameter int Q_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH-1:0]     wlord,
  spike_rate_meter_if.master bus,
  output logic              busy,
  output logic              overrun
);

  localparam int DW    = sprDivWidth(CNT_W, FRAC_W);
  localparam int CH_W  = sprIdxWidth(CH);
  localparam int WIN_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [Q_W-1:0]   Q_MAX   = Q_W'(sprSatMax(Q_W));

  spr_state_e       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [Q_W-1:0]   rate_q, rate_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             overrun_q, overrun_d;
  logic             winEnd, takeSnap, divStart, divByZero, divDone;
  logic [DW-1:0]    divQuo;
  logic [CNT_W-1:0] snapHi [CH];
  logic [CNT_W-1:0] snapLo [CH];

  assign winEnd   = en && (win_q == WIN_W'(WIN - 1));
  assign takeSnap = (state_q == IDLE);

  // The window-end sample is folded into the snapshot while the live counts restart from zero.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] hi_q, lo_q, hiNext, loNext, snapHi_q, snapLo_q;

    always_comb begin
      hiNext = hi_q;
      loNext = lo_q;
      if (wlord[i]) begin
        if (hi_q != CNT_MAX) hiNext = hi_q + 1'b1;
      end else begin
        if (lo_q != CNT_MAX) loNext = lo_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hi_q     <= '0;
        lo_q     <= '0;
        snapHi_q <= '0;
        snapLo_q <= '0;
      end else if (en) begin
        if (winEnd) begin
          hi_q <= '0;
          lo_q <= '0;
          if (takeSnap) begin
            snapHi_q <= hiNext;
            snapLo_q <= loNext;
          end
        end else begin
          hi_q <= hiNext;
          lo_q <= loNext;
        end
      end
    end

    assign snapHi[i] = snapHi_q;
    assign snapLo[i] = snapLo_q;
  end

  spr_seq_divider #(
    .CNT_W (CNT_W),
    .FRAC_W(FRAC_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (divStart),
    .dividend_i ({snapHi[ch_q], {FRAC_W{1'b0}}}),
    .divisor_i  (snapLo[ch_q]),
    .divByZero_o(divByZero),
    .done_o     (divDone),
    .quotient_o (divQuo)
  );

  // Result sequencer; it ignores en so a bank already in flight always completes.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rate_d    = rate_q;
    divStart  = 1'b0;
    win_d     = win_q;
    overrun_d = overrun_q | (winEnd && !takeSnap);
    if (en) win_d = winEnd ? '0 : win_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (winEnd) begin
          ch_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (divByZero) begin
          rate_d  = Q_MAX;
          state_d = OUT;
        end else begin
          divStart = 1'b1;
          state_d  = DIV;
        end
      end
      DIV: begin
        if (divDone) begin
          rate_d  = (|(divQuo >> Q_W)) ? Q_MAX : Q_W'(divQuo);
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (ch_q == CH_W'(CH - 1)) begin
            ch_d    = '0;
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      rate_q    <= '0;
      win_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rate_q    <= rate_d;
      win_q     <= win_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.out_ch    = ch_q;
  assign bus.out_rate  = rate_q;
`ifdef SPR_RAW_OUT_EN
  assign bus.out_hi    = snapHi[ch_q];
  assign bus.out_lo    = snapLo[ch_q];
`endif
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_spike_rate_meter.sv
// Scoreboard bench: two meters (Q_W=8 and Q_W=4) share stimulus; monitors pop expected results on each handshake.
module tb_spike_rate_meter;
  import spr_pkg::*;

  typedef struct {
    int ch;
    int rate;
    int lat;
    int refCyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] wlord = 2'b00;
  logic       ready = 1'b1;
  logic       busy8, busy4, overrun8, overrun4;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q8[$];
  exp_t       q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spike_rate_meter_if #(.CH(2), .Q_W(8)
`ifdef SPR_RAW_OUT_EN
    , .CNT_W(8)
`endif
  ) bus8 ();
  spike_rate_meter_if #(.CH(2), .Q_W(4)
`ifdef SPR_RAW_OUT_EN
    , .CNT_W(8)
`endif
  ) bus4 ();

  assign bus8.out_ready = ready;
  assign bus4.out_ready = ready;

  spike_rate_meter #(.CH(2), .CNT_W(8), .WIN(16), .FRAC_W(4), .Q_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .wlord(wlord), .bus(bus8.master),
    .busy(busy8), .overrun(overrun8)
  );

  spike_rate_meter #(.CH(2), .CNT_W(8), .WIN(16), .FRAC_W(4), .Q_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .wlord(wlord), .bus(bus4.master),
    .busy(busy4), .overrun(overrun4)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // One full window of 16 enabled samples; bit k of p0/p1 is the level on cycle k.
  task automatic applyStimulus(input logic [15:0] p0, input logic [15:0] p1, output int endCyc);
    endCyc = 0;
    for (int k = 0; k < 16; k++) begin
      en    = 1'b1;
      wlord = {p1[k], p0[k]};
      if (k == 15) endCyc = cyc;
      @(posedge clk);
      #1;
    end
    en    = 1'b0;
    wlord = 2'b00;
  endtask

  task automatic pushExp(input int ch, input int r8, input int r4, input int lat, input int refCyc);
    exp_t e;
    e.ch = ch; e.rate = r8; e.lat = lat; e.refCyc = refCyc;
    q8.push_back(e);
    e.rate = r4;
    q4.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int maxCyc);
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0 || busy8 || busy4) && n < maxCyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_q8", q8.size(), 0);
    checkOutput("drain_q4", q4.size(), 0);
    checkOutput("drain_busy", int'(busy8 | busy4), 0);
  endtask

  // Monitor for the Q_W=8 meter, including latency from window end or previous handshake.
  initial begin : mon8
    exp_t e;
    int   gap;
    int   lastHs = 0;
    bit   prevV = 1'b0;
    forever begin
      @(negedge clk);
      if (bus8.out_valid) begin
        if (q8.size() == 0) begin
          checkOutput("unexpected_out8", int'(bus8.out_ch), -1);
        end else begin
          e = q8[0];
          if (!prevV && e.lat >= 0) begin
            gap = cyc - ((e.refCyc >= 0) ? e.refCyc : lastHs);
            checkOutput($sformatf("latency8_ch%0d", e.ch), gap, e.lat);
          end
          if (bus8.out_ready) begin
            void'(q8.pop_front());
            checkOutput("out_ch8", int'(bus8.out_ch), e.ch);
            checkOutput($sformatf("out_rate8_ch%0d", e.ch), int'(bus8.out_rate), e.rate);
            lastHs = cyc;
          end
        end
      end
      prevV = bus8.out_valid;
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          checkOutput("unexpected_out4", int'(bus4.out_ch), -1);
        end else begin
          e = q4.pop_front();
          checkOutput("out_ch4", int'(bus4.out_ch), e.ch);
          checkOutput($sformatf("out_rate4_ch%0d", e.ch), int'(bus4.out_rate), e.rate);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int we;
    idleCycles(3);
    rst = 1'b0;
    idleCycles(1);

    checkOutput("reset_valid", int'(bus8.out_valid), 0);
    checkOutput("reset_ch", int'(bus8.out_ch), 0);
    checkOutput("reset_rate", int'(bus8.out_rate), 0);
    checkOutput("reset_busy", int'(busy8), 0);
    checkOutput("reset_overrun", int'(overrun8), 0);

    // ch0 held high (divide by zero), ch1 alternating 8/8.
    applyStimulus(16'hFFFF, 16'h5555, we);
    checkOutput("busy_after_window", int'(busy8), 1);
    pushExp(0, 'hFF, 'hF, 2, we);
    pushExp(1, 'h10, 'hF, 14, -1);
    waitDrain(100);

    // ch0 all low, ch1 high 12 of 16.
    applyStimulus(16'h0000, 16'h0FFF, we);
    pushExp(0, 'h00, 'h0, 14, we);
    pushExp(1, 'h30, 'hF, 14, -1);
    waitDrain(100);

    // ch0 15 high / 1 low saturates the narrow meter; ch1 1 high / 15 low.
    applyStimulus(16'h7FFF, 16'h0001, we);
    pushExp(0, 'hF0, 'hF, 14, we);
    pushExp(1, 'h01, 'h1, 14, -1);
    waitDrain(100);

    // Backpressure: the second window lands while the first bank is held.
    ready = 1'b0;
    applyStimulus(16'h000F, 16'hFFFF, we);
    pushExp(0, 5, 5, 14, we);
    pushExp(1, 'hFF, 'hF, 2, -1);
    idleCycles(20);
    checkOutput("held_valid", int'(bus8.out_valid), 1);
    applyStimulus(16'h00FF, 16'h0F0F, we);
    idleCycles(2);
    checkOutput("overrun8_set", int'(overrun8), 1);
    checkOutput("overrun4_set", int'(overrun4), 1);
    checkOutput("held_ch", int'(bus8.out_ch), 0);
    checkOutput("held_rate", int'(bus8.out_rate), 5);
    ready = 1'b1;
    waitDrain(100);
    idleCycles(30);
    checkOutput("dropped_bank_valid", int'(bus8.out_valid), 0);
    checkOutput("overrun_sticky", int'(overrun8), 1);

    // Reset five cycles into the division; no output may escape.
    applyStimulus(16'h00FF, 16'h5555, we);
    idleCycles(5);
    checkOutput("busy_in_div", int'(busy8), 1);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("rst_valid", int'(bus8.out_valid), 0);
    checkOutput("rst_busy", int'(busy8), 0);
    checkOutput("rst_overrun", int'(overrun8), 0);
    checkOutput("rst_rate", int'(bus8.out_rate), 0);
    idleCycles(20);
    checkOutput("rst_no_output", int'(bus8.out_valid), 0);

    // Fresh window after the reset: ch0 2/14, ch1 10/6.
    applyStimulus(16'h0003, 16'h03FF, we);
    pushExp(0, 2, 2, 14, we);
    pushExp(1, 'h1A, 'hF, 14, -1);
    waitDrain(100);
    idleCycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
